// File: rtl/mux_sched_pkg.sv
// rtl/mux_sched_pkg.sv - shared constants and state encoding for the round-robin mux scheduler
package mux_sched_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/mux_8_1_rr_sched_rr_pick_8.sv
// rtl/mux_8_1_rr_sched_rr_pick_8.sv - combinational round-robin picker: first request after ptr, wrapping
module rr_pick_8
    import mux_sched_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest set bit after ptr wins;
    // offset N_CH wraps to ptr itself, giving the last-served channel lowest priority.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = '0;
        for (int k = N_CH; k >= 1; k--) begin
            cand = ptr + k[SEL_W-1:0];
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_8_1_rr_sched.sv
// rtl/mux_8_1_rr_sched.sv - round-robin 8:1 mux scheduler with break-before-make gap; MUX_SCHED_TIMEOUT_EN adds hold timeout
module mux_8_1_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [N_CH-1:0]  i_req,
    input  logic             i_release,
    output logic [N_CH-1:0]  o_gnt,
    output logic [SEL_W-1:0] o_sel_code,
    output logic             o_mux_en,
    output logic             o_busy,
    output logic             o_timeout
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [N_CH-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             tmo_q, tmo_d;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             start_grant;
    logic             owner_req;
    logic             hold_expired;

    rr_pick_8 u_pick (
        .req   (i_req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign start_grant = i_en & pick_found;
    assign owner_req   = i_req[sel_q];

`ifdef MUX_SCHED_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign hold_expired = (state_q == ST_HOLD) && (cnt_q == CNT_W'(HOLD_MAX - 1));

    // Hold counter: cleared on every new grant, counts cycles spent in HOLD.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_HOLD) begin
            cnt_d = cnt_q + 1'b1;
        end
        if ((state_q != ST_HOLD) && start_grant) begin
            cnt_d = '0;
        end
    end

    // Hold counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cfg;

    assign hold_expired = 1'b0;
    assign unused_cfg   = (HOLD_MAX > 0) && (CNT_W > 0);
`endif

    // Next-state: arbitrate in IDLE/GAP, watch for release/drop/expiry in HOLD.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        tmo_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (start_grant) begin
                    state_d = ST_HOLD;
                    ptr_d   = pick_idx;
                    sel_d   = pick_idx;
                    gnt_d   = N_CH'(1) << pick_idx;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (i_release || !owner_req || hold_expired) begin
                    state_d = ST_GAP;
                    gnt_d   = '0;
                    tmo_d   = hold_expired & ~i_release;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State, pointer and output registers; reset makes ch0 the first winner.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= SEL_W'(N_CH - 1);
            gnt_q   <= '0;
            sel_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            tmo_q   <= tmo_d;
        end
    end

    assign o_gnt      = gnt_q;
    assign o_sel_code = sel_q;
    assign o_mux_en   = (state_q == ST_HOLD);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_timeout  = tmo_q;

endmodule
